// File: rtl/pll_cen_gen.sv
// rtl/pll_cen_gen.sv - lock-qualified reset sequencer and fractional clock-enable generator
module pll_cen_gen #(
    parameter int NUM_CH      = 2,
    parameter int ACC_W       = 16,
    parameter int LOCK_CYCLES = 1024,
    parameter logic [NUM_CH*ACC_W-1:0] INC_INIT = {16'h3333, 16'h6666}
) (
    input  logic                     refclk,
    input  logic                     rst_n,
    input  logic                     pll_locked,
    input  logic [NUM_CH*ACC_W-1:0]  inc_in,
    input  logic                     inc_load,
    input  logic                     sync_clr,
    output logic [NUM_CH-1:0]        cen,
    output logic                     ready,
    output logic                     sys_rst_n
);

    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    localparam logic [1:0] S_WAIT   = 2'd0;
    localparam logic [1:0] S_STABLE = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;

    logic                    r_sync1;
    logic                    r_sync2;
    logic [1:0]              r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_ready;
    logic                    r_sys_rst_n;
    logic [NUM_CH*ACC_W-1:0] r_inc;
    logic [ACC_W-1:0]        r_acc [NUM_CH];
    logic [NUM_CH-1:0]       r_cen;

    logic                    w_lk_s;
    logic [1:0]              w_state_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    w_add;
    logic [ACC_W:0]          w_sum [NUM_CH];

    assign w_lk_s = r_sync2;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            S_WAIT: begin
                if (w_lk_s) w_state_nxt = S_STABLE;
            end
            S_STABLE: begin
                if (!w_lk_s) begin
                    w_state_nxt = S_WAIT;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!w_lk_s) w_state_nxt = S_WAIT;
            end
            default: w_state_nxt = S_WAIT;
        endcase
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_state     <= S_WAIT;
            r_cnt       <= '0;
            r_ready     <= 1'b0;
            r_sys_rst_n <= 1'b0;
            r_inc       <= INC_INIT;
        end else begin
            r_sync1     <= pll_locked;
            r_sync2     <= r_sync1;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ready     <= (w_state_nxt == S_RUN);
            r_sys_rst_n <= (w_state_nxt == S_RUN);
            if (inc_load) r_inc <= inc_in;
        end
    end

    // Add only while staying in RUN; the exit edge and sync_clr both force acc/cen to 0.
    assign w_add = (r_state == S_RUN) && w_lk_s && !sync_clr;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_sum[i] = {1'b0, r_acc[i]} + {1'b0, r_inc[i*ACC_W +: ACC_W]};
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
            r_cen <= '0;
        end else if (w_add) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i] <= w_sum[i][ACC_W-1:0];
                r_cen[i] <= w_sum[i][ACC_W];
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
            r_cen <= '0;
        end
    end

    assign cen       = r_cen;
    assign ready     = r_ready;
    assign sys_rst_n = r_sys_rst_n;

endmodule

// File: tb/tb_pll_cen_gen.sv
// tb/tb_pll_cen_gen.sv - directed self-checking bench for pll_cen_gen
module tb_pll_cen_gen;

    logic        refclk = 1'b0;
    logic        rst_n;
    logic        pll_locked;
    logic [31:0] inc_in;
    logic        inc_load;
    logic        sync_clr;
    logic [1:0]  cen;
    logic        ready;
    logic        sys_rst_n;

    int n_vec = 0;
    int n_err = 0;

    pll_cen_gen dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .inc_in     (inc_in),
        .inc_load   (inc_load),
        .sync_clr   (sync_clr),
        .cen        (cen),
        .ready      (ready),
        .sys_rst_n  (sys_rst_n)
    );

    always #5 refclk = ~refclk;

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        inc_in     = '0;
        inc_load   = 1'b0;
        sync_clr   = 1'b0;
        step();
        step();
        n_vec++;
        if ({cen, ready, sys_rst_n} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_state: got cen=%b ready=%b sys_rst_n=%b, want all 0", cen, ready, sys_rst_n);
        end
    endtask

    // Default increments: ch0=0x6666 first carry at add 3, ch1=0x3333 first at add 6.
    task automatic test_first_pulses(input string tag);
        logic [1:0] exp_seq [0:5];
        exp_seq = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b11};
        for (int k = 0; k < 6; k++) begin
            step();
            n_vec++;
            if (cen !== exp_seq[k]) begin
                n_err++;
                $display("FAIL %s_first_pulse[%0d]: got cen=%b want %b", tag, k + 1, cen, exp_seq[k]);
            end
        end
    endtask

    task automatic test_lock_seq();
        int bad_edge;
        bad_edge = 0;
        rst_n = 1'b1;
        for (int e = 1; e <= 1027; e++) begin
            step();
            if (e < 1027 && (ready !== 1'b0 || sys_rst_n !== 1'b0 || cen !== 2'b00) && bad_edge == 0)
                bad_edge = e;
        end
        n_vec++;
        if (bad_edge != 0) begin
            n_err++;
            $display("FAIL lock_early: outputs active at edge %0d, want idle before edge 1027", bad_edge);
        end
        n_vec++;
        if (ready !== 1'b1 || sys_rst_n !== 1'b1) begin
            n_err++;
            $display("FAIL lock_run_entry: got ready=%b sys_rst_n=%b at edge 1027, want 1/1", ready, sys_rst_n);
        end
        test_first_pulses("lock");
    endtask

    task automatic test_rates();
        int c0, c1;
        bit back2back;
        logic prev0;
        c0 = 0; c1 = 0; back2back = 0; prev0 = 1'b0;
        for (int k = 0; k < 65536; k++) begin
            step();
            c0 += int'(cen[0]);
            c1 += int'(cen[1]);
            if (prev0 && cen[0]) back2back = 1;
            prev0 = cen[0];
        end
        n_vec++;
        if (c0 != 26214) begin
            n_err++;
            $display("FAIL rate_ch0: got %0d pulses want 26214", c0);
        end
        n_vec++;
        if (c1 != 13107) begin
            n_err++;
            $display("FAIL rate_ch1: got %0d pulses want 13107", c1);
        end
        n_vec++;
        if (back2back) begin
            n_err++;
            $display("FAIL rate_spacing: got adjacent cen[0] pulses want spacing >= 2");
        end
    endtask

    task automatic test_sync_clr();
        inc_in   = {16'h4000, 16'h4000};
        inc_load = 1'b1;
        step();
        inc_load = 1'b0;
        step();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        n_vec++;
        if (cen !== 2'b00) begin
            n_err++;
            $display("FAIL clr_cycle: got cen=%b want 00", cen);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            n_vec++;
            if (cen !== ((k % 4 == 0) ? 2'b11 : 2'b00)) begin
                n_err++;
                $display("FAIL clr_pulse[%0d]: got cen=%b want %b", k, cen, (k % 4 == 0) ? 2'b11 : 2'b00);
            end
        end
    endtask

    task automatic test_inc_load();
        // Simultaneous clear and load: new increments apply from the following add.
        inc_in   = {16'h0000, 16'h8000};
        inc_load = 1'b1;
        sync_clr = 1'b1;
        step();
        inc_load = 1'b0;
        sync_clr = 1'b0;
        n_vec++;
        if (cen !== 2'b00) begin
            n_err++;
            $display("FAIL load_clr_cycle: got cen=%b want 00", cen);
        end
        for (int k = 1; k <= 6; k++) begin
            step();
            n_vec++;
            if (cen !== ((k % 2 == 0) ? 2'b01 : 2'b00)) begin
                n_err++;
                $display("FAIL load_half_rate[%0d]: got cen=%b want %b", k, cen, (k % 2 == 0) ? 2'b01 : 2'b00);
            end
        end
        // Load while acc=0x4000: add uses old inc -> 0x8000, then new 0x8000 carries next.
        inc_in   = {16'h4000, 16'h4000};
        inc_load = 1'b1;
        sync_clr = 1'b1;
        step();
        inc_load = 1'b0;
        sync_clr = 1'b0;
        step();
        inc_in   = {16'h0000, 16'h8000};
        inc_load = 1'b1;
        step();
        inc_load = 1'b0;
        n_vec++;
        if (cen !== 2'b00) begin
            n_err++;
            $display("FAIL load_cont_a: got cen=%b want 00", cen);
        end
        step();
        n_vec++;
        if (cen !== 2'b01) begin
            n_err++;
            $display("FAIL load_cont_b: got cen=%b want 01", cen);
        end
        step();
        n_vec++;
        if (cen !== 2'b00) begin
            n_err++;
            $display("FAIL load_cont_c: got cen=%b want 00", cen);
        end
    endtask

    task automatic test_async_reset();
        inc_in   = {16'h8000, 16'h7FFF};
        inc_load = 1'b1;
        sync_clr = 1'b1;
        step();
        inc_load = 1'b0;
        sync_clr = 1'b0;
        step();
        n_vec++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL areset_pre: got ready=%b want 1", ready);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({cen, ready, sys_rst_n} !== 4'b0000) begin
            n_err++;
            $display("FAIL areset_immediate: got cen=%b ready=%b sys_rst_n=%b want all 0", cen, ready, sys_rst_n);
        end
        step();
        rst_n = 1'b1;
        for (int e = 1; e <= 1027; e++) step();
        n_vec++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL areset_relock: got ready=%b want 1", ready);
        end
        test_first_pulses("areset");
    endtask

    task automatic test_glitch_and_drop();
        int bad_edge;
        bad_edge = 0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int e = 1; e <= 1531; e++) begin
            step();
            if (e == 503) pll_locked = 1'b0;
            if (e == 504) pll_locked = 1'b1;
            if (e < 1531 && ready !== 1'b0 && bad_edge == 0) bad_edge = e;
        end
        n_vec++;
        if (bad_edge != 0) begin
            n_err++;
            $display("FAIL glitch_restart: ready high at edge %0d, want low before edge 1531", bad_edge);
        end
        n_vec++;
        if (ready !== 1'b1 || sys_rst_n !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_run: got ready=%b sys_rst_n=%b at edge 1531 want 1/1", ready, sys_rst_n);
        end
        for (int k = 0; k < 20; k++) step();
        pll_locked = 1'b0;
        step();
        step();
        n_vec++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL drop_latency: got ready=%b two edges after drop want 1", ready);
        end
        step();
        n_vec++;
        if ({cen, ready, sys_rst_n} !== 4'b0000) begin
            n_err++;
            $display("FAIL drop_exit: got cen=%b ready=%b sys_rst_n=%b want all 0", cen, ready, sys_rst_n);
        end
    endtask

    initial begin
        test_reset();
        test_lock_seq();
        test_rates();
        test_sync_clr();
        test_inc_load();
        test_async_reset();
        test_glitch_and_drop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
